// File: rtl/vend_port_arbiter.sv
// vend_port_arbiter: shares one vending core among PORTS customer panels.
// Round-robin grants one panel per purchase session, forwards its coins and routes core responses back.

module vend_port_lane (
  input  logic clk,
  input  logic i_rst_n,
  input  logic owned,
  input  logic grant,
  input  logic coin_open,
  input  logic coin_strobe,
  input  logic vm_change_strobe,
  input  logic vm_no_change,
  input  logic vm_give_strobe,
  output logic coin_ready,
  output logic coin_acc,
  output logic change_strobe,
  output logic no_change,
  output logic give_strobe
);
  assign coin_ready = grant & coin_open;
  assign coin_acc   = coin_ready & coin_strobe;

  // owned follows the last granted panel, so responses after busy-fall still land here
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      change_strobe <= 1'b0;
      no_change     <= 1'b0;
      give_strobe   <= 1'b0;
    end else begin
      change_strobe <= owned & vm_change_strobe;
      no_change     <= owned & vm_no_change;
      give_strobe   <= owned & vm_give_strobe;
    end
  end
endmodule

module vend_port_arbiter #(
  parameter int PORTS          = 4,
  parameter int PRODUCT_WIDTH  = 2,
  parameter int CURRENCY_WIDTH = 3,
  parameter int COUNT_WIDTH    = 16,
  parameter int START_TIMEOUT  = 8
) (
  input  logic                                clk,
  input  logic                                i_rst_n,
  input  logic [PORTS-1:0]                    i_req,
  input  logic [PORTS*PRODUCT_WIDTH-1:0]      i_req_product,
  input  logic [PORTS-1:0]                    i_coin_strobe,
  input  logic [PORTS*CURRENCY_WIDTH-1:0]     i_coin_code,
  output logic [PORTS-1:0]                    o_grant,
  output logic [PORTS-1:0]                    o_coin_ready,
  output logic [CURRENCY_WIDTH-1:0]           o_change,
  output logic [PORTS-1:0]                    o_change_strobe,
  output logic [PORTS-1:0]                    o_no_change,
  output logic [PORTS-1:0]                    o_give_strobe,
  output logic [PRODUCT_WIDTH-1:0]            o_product,
  output logic                                o_launch_err,
  output logic [COUNT_WIDTH-1:0]              o_vend_count,
  output logic [COUNT_WIDTH-1:0]              o_no_change_count,
  output logic [PRODUCT_WIDTH-1:0]            vm_product_code,
  output logic                                vm_product_strobe,
  output logic [CURRENCY_WIDTH-1:0]           vm_currency_code,
  output logic                                vm_currency_strobe,
  input  logic                                vm_busy,
  input  logic                                vm_ready_to_receive,
  input  logic                                vm_change_strobe,
  input  logic                                vm_no_change,
  input  logic                                vm_give_strobe,
  input  logic [CURRENCY_WIDTH-1:0]           vm_change,
  input  logic [PRODUCT_WIDTH-1:0]            vm_product
);
  localparam int OW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, SESSION} state_t;

  state_t                                  state, state_nx;
  logic [OW-1:0]                           rr_ptr, rr_nx, owner, owner_nx, owner_inc, winner;
  logic [TW-1:0]                           tmo_cnt, tmo_nx;
  logic [PORTS-1:0]                        grant_nx, coin_acc;
  logic [PRODUCT_WIDTH-1:0]                pcode_nx;
  logic                                    pstrobe_nx, launch_err_nx, found;
  logic                                    coin_pending, coin_open, coin_any, chg_req, session;
  logic [PORTS-1:0][PRODUCT_WIDTH-1:0]     req_prod;
  logic [PORTS-1:0][CURRENCY_WIDTH-1:0]    coin_codes;
  int                                      idx;

  assign req_prod   = i_req_product;
  assign coin_codes = i_coin_code;
  assign session    = (state == SESSION);
  assign coin_open  = session & vm_ready_to_receive & ~coin_pending;
  assign coin_any   = |coin_acc;
  // ready_to_receive low keeps the change request off while a coin could be accepted
  assign chg_req    = session & vm_busy & ~vm_ready_to_receive & ~coin_pending;
  assign owner_inc  = (owner == OW'(PORTS - 1)) ? '0 : owner + OW'(1);

  // walk downward so the smallest offset from rr_ptr wins
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % PORTS;
      if (i_req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  always_comb begin
    state_nx      = state;
    rr_nx         = rr_ptr;
    owner_nx      = owner;
    grant_nx      = o_grant;
    tmo_nx        = tmo_cnt;
    pcode_nx      = vm_product_code;
    pstrobe_nx    = 1'b0;
    launch_err_nx = 1'b0;
    case (state)
      IDLE: begin
        if (found && !vm_busy) begin
          grant_nx   = PORTS'(1) << winner;
          owner_nx   = winner;
          pcode_nx   = req_prod[winner];
          pstrobe_nx = 1'b1;
          state_nx   = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_nx   = '0;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (vm_busy) begin
          state_nx = SESSION;
        end else begin
          tmo_nx = tmo_cnt + TW'(1);
          if (tmo_nx == TW'(START_TIMEOUT)) begin
            launch_err_nx = 1'b1;
            grant_nx      = '0;
            rr_nx         = owner_inc;
            state_nx      = IDLE;
          end
        end
      end
      SESSION: begin
        if (!vm_busy) begin
          grant_nx = '0;
          rr_nx    = owner_inc;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      owner              <= '0;
      o_grant            <= '0;
      tmo_cnt            <= '0;
      o_launch_err       <= 1'b0;
      vm_product_code    <= '0;
      vm_product_strobe  <= 1'b0;
      vm_currency_code   <= '0;
      vm_currency_strobe <= 1'b0;
      coin_pending       <= 1'b0;
      o_change           <= '0;
      o_product          <= '0;
      o_vend_count       <= '0;
      o_no_change_count  <= '0;
    end else begin
      state              <= state_nx;
      rr_ptr             <= rr_nx;
      owner              <= owner_nx;
      o_grant            <= grant_nx;
      tmo_cnt            <= tmo_nx;
      o_launch_err       <= launch_err_nx;
      vm_product_code    <= pcode_nx;
      vm_product_strobe  <= pstrobe_nx;
      coin_pending       <= coin_any;
      vm_currency_strobe <= coin_any | chg_req;
      vm_currency_code   <= coin_any ? coin_codes[owner] : '0;
      if (vm_change_strobe) o_change <= vm_change;
      if (vm_give_strobe) begin
        o_product    <= vm_product;
        o_vend_count <= o_vend_count + COUNT_WIDTH'(1);
      end
      if (vm_no_change) o_no_change_count <= o_no_change_count + COUNT_WIDTH'(1);
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    vend_port_lane u_lane (
      .clk              (clk),
      .i_rst_n          (i_rst_n),
      .owned            (owner == OW'(p)),
      .grant            (o_grant[p]),
      .coin_open        (coin_open),
      .coin_strobe      (i_coin_strobe[p]),
      .vm_change_strobe (vm_change_strobe),
      .vm_no_change     (vm_no_change),
      .vm_give_strobe   (vm_give_strobe),
      .coin_ready       (o_coin_ready[p]),
      .coin_acc         (coin_acc[p]),
      .change_strobe    (o_change_strobe[p]),
      .no_change        (o_no_change[p]),
      .give_strobe      (o_give_strobe[p])
    );
  end
endmodule

// File: tb/tb_vend_port_arbiter.sv
// Scoreboard bench for vend_port_arbiter: the bench plays the vending core and the panels,
// queues expected core strobes / panel responses and checks them as they appear.
module tb_vend_port_arbiter;
  localparam int PORTS = 4, PW = 2, CW = 3, NW = 16, TMO = 8;

  logic clk = 1'b0, i_rst_n = 1'b0;
  logic [PORTS-1:0]    i_req, i_coin_strobe;
  logic [PORTS*PW-1:0] i_req_product;
  logic [PORTS*CW-1:0] i_coin_code;
  logic [PORTS-1:0]    o_grant, o_coin_ready, o_change_strobe, o_no_change, o_give_strobe;
  logic [CW-1:0]       o_change, vm_currency_code, vm_change;
  logic [PW-1:0]       o_product, vm_product_code, vm_product;
  logic                o_launch_err, vm_product_strobe, vm_currency_strobe;
  logic [NW-1:0]       o_vend_count, o_no_change_count;
  logic vm_busy, vm_ready_to_receive, vm_change_strobe, vm_no_change, vm_give_strobe;

  int checks = 0, errors = 0;
  int                    cur_q[$];
  logic [PORTS+CW-1:0]   chg_q[$];
  logic [PORTS-1:0]      nc_q[$];
  logic [PORTS+PW-1:0]   give_q[$];
  int                    m_code;
  logic [PORTS+CW-1:0]   m_chg;
  logic [PORTS-1:0]      m_nc;
  logic [PORTS+PW-1:0]   m_give;

  vend_port_arbiter #(.PORTS(PORTS), .PRODUCT_WIDTH(PW), .CURRENCY_WIDTH(CW),
                      .COUNT_WIDTH(NW), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_req_product(i_req_product),
    .i_coin_strobe(i_coin_strobe), .i_coin_code(i_coin_code), .o_grant(o_grant),
    .o_coin_ready(o_coin_ready), .o_change(o_change), .o_change_strobe(o_change_strobe),
    .o_no_change(o_no_change), .o_give_strobe(o_give_strobe), .o_product(o_product),
    .o_launch_err(o_launch_err), .o_vend_count(o_vend_count),
    .o_no_change_count(o_no_change_count), .vm_product_code(vm_product_code),
    .vm_product_strobe(vm_product_strobe), .vm_currency_code(vm_currency_code),
    .vm_currency_strobe(vm_currency_strobe), .vm_busy(vm_busy),
    .vm_ready_to_receive(vm_ready_to_receive), .vm_change_strobe(vm_change_strobe),
    .vm_no_change(vm_no_change), .vm_give_strobe(vm_give_strobe),
    .vm_change(vm_change), .vm_product(vm_product)
  );

  always #5 clk = ~clk;

  // scoreboard: every core strobe / panel response must match the head of its queue
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (vm_currency_strobe) begin
        checks++;
        if (cur_q.size() == 0) begin
          errors++; $display("FAIL cur_strobe unexpected code=%0d", vm_currency_code);
        end else begin
          m_code = cur_q.pop_front();
          if (vm_currency_code !== CW'(m_code)) begin
            errors++; $display("FAIL cur_code got=%0d exp=%0d", vm_currency_code, m_code);
          end
        end
      end
      if (o_change_strobe !== '0) begin
        checks++;
        if (chg_q.size() == 0) begin
          errors++; $display("FAIL change unexpected strobe=%b", o_change_strobe);
        end else begin
          m_chg = chg_q.pop_front();
          if ({o_change_strobe, o_change} !== m_chg) begin
            errors++; $display("FAIL change got=%b/%0d exp=%b", o_change_strobe, o_change, m_chg);
          end
        end
      end
      if (o_no_change !== '0) begin
        checks++;
        if (nc_q.size() == 0) begin
          errors++; $display("FAIL no_change unexpected strobe=%b", o_no_change);
        end else begin
          m_nc = nc_q.pop_front();
          if (o_no_change !== m_nc) begin
            errors++; $display("FAIL no_change got=%b exp=%b", o_no_change, m_nc);
          end
        end
      end
      if (o_give_strobe !== '0) begin
        checks++;
        if (give_q.size() == 0) begin
          errors++; $display("FAIL give unexpected strobe=%b", o_give_strobe);
        end else begin
          m_give = give_q.pop_front();
          if ({o_give_strobe, o_product} !== m_give) begin
            errors++; $display("FAIL give got=%b/%0d exp=%b", o_give_strobe, o_product, m_give);
          end
        end
      end
    end
  end

  task automatic set_prod(input int p, input int c);
    i_req_product[p*PW +: PW] = PW'(c);
  endtask

  task automatic set_coin(input int p, input int c);
    i_coin_code[p*CW +: CW] = CW'(c);
  endtask

  task automatic wait_grant(output logic [PORTS-1:0] g, output logic [PW-1:0] pc, output logic ps);
    bit done;
    g = '0; pc = '0; ps = 1'b0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (o_grant !== '0) begin
        g = o_grant; pc = vm_product_code; ps = vm_product_strobe; done = 1;
      end
    end
  endtask

  task automatic quick_session();
    @(negedge clk); vm_busy = 1'b1; vm_ready_to_receive = 1'b1;
    @(negedge clk); vm_busy = 1'b0;
    @(negedge clk); vm_ready_to_receive = 1'b0;
  endtask

  task automatic test_reset();
    i_req = '0; i_req_product = '0; i_coin_strobe = '0; i_coin_code = '0;
    vm_busy = 0; vm_ready_to_receive = 0; vm_change_strobe = 0; vm_no_change = 0;
    vm_give_strobe = 0; vm_change = '0; vm_product = '0;
    i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_grant, o_coin_ready, o_change_strobe, o_no_change, o_give_strobe, o_launch_err,
         vm_product_strobe, vm_currency_strobe} !== '0) begin
      errors++; $display("FAIL reset_strobes got grant=%b prod_stb=%b cur_stb=%b exp 0",
                         o_grant, vm_product_strobe, vm_currency_strobe);
    end
    checks++;
    if ({o_vend_count, o_no_change_count} !== '0) begin
      errors++; $display("FAIL reset_counts got=%0d/%0d exp 0", o_vend_count, o_no_change_count);
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_grant !== '0) begin errors++; $display("FAIL idle_grant got=%b exp 0", o_grant); end
  endtask

  task automatic test_round_robin();
    logic [PORTS-1:0] g; logic [PW-1:0] pc; logic ps;
    int ord[3] = '{0, 2, 3};
    set_prod(0, 1); set_prod(2, 2); set_prod(3, 3);
    i_req = 4'b1101;
    for (int n = 0; n < 3; n++) begin
      wait_grant(g, pc, ps);
      checks++;
      if (g !== PORTS'(1 << ord[n])) begin
        errors++; $display("FAIL rr_grant%0d got=%b exp=%b", n, g, PORTS'(1 << ord[n]));
      end
      checks++;
      if (pc !== PW'(n + 1) || ps !== 1'b1) begin
        errors++; $display("FAIL rr_launch%0d got code=%0d stb=%b exp code=%0d stb=1", n, pc, ps, n + 1);
      end
      i_req[ord[n]] = 1'b0;
      quick_session();
    end
    // pointer must have wrapped to 0 after port3: port0 beats port1
    i_req = 4'b0011;
    wait_grant(g, pc, ps);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL rr_wrap got=%b exp=0001", g); end
    i_req = '0;
    quick_session();
  endtask

  task automatic test_single_buyer();
    logic [PORTS-1:0] g; logic [PW-1:0] pc; logic ps;
    set_prod(1, 0); i_req = 4'b0010;
    wait_grant(g, pc, ps);
    checks++;
    if (g !== 4'b0010 || pc !== 2'd0 || ps !== 1'b1) begin
      errors++; $display("FAIL sb_grant got=%b/%0d/%b exp=0010/0/1", g, pc, ps);
    end
    i_req = '0;
    @(negedge clk);
    checks++;
    if (vm_product_strobe !== 1'b0) begin
      errors++; $display("FAIL sb_pstrobe_len got=%b exp=0", vm_product_strobe);
    end
    vm_busy = 1'b1; vm_ready_to_receive = 1'b1;
    @(negedge clk);
    checks++;
    if (o_coin_ready !== 4'b0010) begin
      errors++; $display("FAIL sb_coin_ready got=%b exp=0010", o_coin_ready);
    end
    i_coin_strobe = 4'b0010; set_coin(1, 2); cur_q.push_back(2);
    @(negedge clk);
    i_coin_strobe = '0; vm_ready_to_receive = 1'b0; vm_busy = 1'b0;
    vm_give_strobe = 1'b1; vm_product = 2'd0; give_q.push_back({4'b0010, 2'd0});
    @(negedge clk);
    vm_give_strobe = 1'b0;
    checks++;
    if (o_grant !== '0 || o_vend_count !== 16'd1) begin
      errors++; $display("FAIL sb_end got grant=%b count=%0d exp 0/1", o_grant, o_vend_count);
    end
  endtask

  task automatic test_change();
    logic [PORTS-1:0] g; logic [PW-1:0] pc; logic ps;
    set_prod(0, 0); i_req = 4'b0001;
    wait_grant(g, pc, ps);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL chg_grant got=%b exp=0001", g); end
    i_req = '0;
    @(negedge clk); vm_busy = 1'b1; vm_ready_to_receive = 1'b1;
    @(negedge clk); i_coin_strobe = 4'b0001; set_coin(0, 3); cur_q.push_back(3);
    @(negedge clk);
    i_coin_strobe = '0; vm_ready_to_receive = 1'b0;
    cur_q.push_back(0); cur_q.push_back(0);
    @(negedge clk);
    checks++;
    if (vm_currency_strobe !== 1'b0) begin
      errors++; $display("FAIL chg_pending_gap got=%b exp=0", vm_currency_strobe);
    end
    @(negedge clk);
    vm_change_strobe = 1'b1; vm_change = 3'd2; chg_q.push_back({4'b0001, 3'd2});
    @(negedge clk);
    vm_change_strobe = 1'b0; vm_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (o_grant !== '0 || vm_currency_strobe !== 1'b0) begin
      errors++; $display("FAIL chg_end got grant=%b cur_stb=%b exp 0/0", o_grant, vm_currency_strobe);
    end
    vm_give_strobe = 1'b1; vm_product = 2'd0; give_q.push_back({4'b0001, 2'd0});
    @(negedge clk);
    vm_give_strobe = 1'b0;
    checks++;
    if (o_vend_count !== 16'd2) begin
      errors++; $display("FAIL chg_vend_count got=%0d exp=2", o_vend_count);
    end
  endtask

  task automatic test_coin_gating();
    logic [PORTS-1:0] g; logic [PW-1:0] pc; logic ps;
    set_prod(2, 1); i_req = 4'b0100;
    wait_grant(g, pc, ps);
    checks++;
    if (g !== 4'b0100 || pc !== 2'd1) begin
      errors++; $display("FAIL gate_grant got=%b/%0d exp=0100/1", g, pc);
    end
    i_req = '0;
    @(negedge clk); vm_busy = 1'b1; vm_ready_to_receive = 1'b1;
    @(negedge clk);
    checks++;
    if (o_coin_ready !== 4'b0100) begin
      errors++; $display("FAIL gate_ready got=%b exp=0100", o_coin_ready);
    end
    i_coin_strobe = 4'b0110; set_coin(1, 5); set_coin(2, 1); cur_q.push_back(1);
    @(negedge clk);
    checks++;
    if (o_coin_ready !== 4'b0000) begin
      errors++; $display("FAIL gate_pending got=%b exp=0000", o_coin_ready);
    end
    set_coin(2, 4);
    @(negedge clk);
    i_coin_strobe = '0;
    checks++;
    if (o_coin_ready !== 4'b0100) begin
      errors++; $display("FAIL gate_reopen got=%b exp=0100", o_coin_ready);
    end
    vm_no_change = 1'b1; nc_q.push_back(4'b0100);
    @(negedge clk);
    vm_no_change = 1'b0;
    checks++;
    if (o_no_change_count !== 16'd1) begin
      errors++; $display("FAIL gate_nc_count got=%0d exp=1", o_no_change_count);
    end
    vm_busy = 1'b0;
    @(negedge clk);
    vm_ready_to_receive = 1'b0;
  endtask

  task automatic test_launch_err();
    logic [PORTS-1:0] g; logic [PW-1:0] pc; logic ps;
    int n;
    vm_busy = 1'b0; vm_ready_to_receive = 1'b0;
    set_prod(3, 2); set_prod(0, 3); i_req = 4'b1001;
    wait_grant(g, pc, ps);
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL lerr_grant got=%b exp=1000", g); end
    i_req[3] = 1'b0;
    n = 0;
    for (int k = 1; k <= 30 && n == 0; k++) begin
      @(negedge clk);
      if (o_launch_err) n = k;
    end
    checks++;
    if (n != TMO + 1) begin errors++; $display("FAIL lerr_delay got=%0d exp=%0d", n, TMO + 1); end
    checks++;
    if (o_grant !== '0) begin errors++; $display("FAIL lerr_grant_clr got=%b exp=0", o_grant); end
    wait_grant(g, pc, ps);
    checks++;
    if (g !== 4'b0001 || pc !== 2'd3 || o_launch_err !== 1'b0) begin
      errors++; $display("FAIL lerr_next got=%b/%0d err=%b exp=0001/3 err=0", g, pc, o_launch_err);
    end
    i_req = '0;
    quick_session();
  endtask

  task automatic test_reset_mid_change();
    logic [PORTS-1:0] g; logic [PW-1:0] pc; logic ps;
    set_prod(1, 1); i_req = 4'b0010;
    wait_grant(g, pc, ps);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL rst_grant got=%b exp=0010", g); end
    i_req = '0;
    @(negedge clk); vm_busy = 1'b1; vm_ready_to_receive = 1'b1;
    @(negedge clk); i_coin_strobe = 4'b0010; set_coin(1, 3); cur_q.push_back(3);
    @(negedge clk); i_coin_strobe = '0; vm_ready_to_receive = 1'b0; cur_q.push_back(0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (vm_currency_strobe !== 1'b1 || o_vend_count !== 16'd2) begin
      errors++; $display("FAIL rst_pre got cur_stb=%b vend=%0d exp 1/2", vm_currency_strobe, o_vend_count);
    end
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_grant, o_coin_ready, o_launch_err, vm_product_strobe, vm_currency_strobe,
         vm_currency_code, vm_product_code} !== '0) begin
      errors++; $display("FAIL rst_async got grant=%b cur_stb=%b exp 0", o_grant, vm_currency_strobe);
    end
    checks++;
    if ({o_vend_count, o_no_change_count} !== '0) begin
      errors++; $display("FAIL rst_counts got=%0d/%0d exp 0", o_vend_count, o_no_change_count);
    end
    vm_busy = 1'b0;
    @(negedge clk); i_rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_buyer();
    test_change();
    test_coin_gating();
    test_launch_err();
    test_reset_mid_change();
    checks++;
    if (cur_q.size() + chg_q.size() + nc_q.size() + give_q.size() != 0) begin
      errors++; $display("FAIL leftover got cur=%0d chg=%0d nc=%0d give=%0d exp 0",
                         cur_q.size(), chg_q.size(), nc_q.size(), give_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
